div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  divide request from execute stage; high when the registered aluopE is ALUOP_DIV or ALUOP_DIVU, held until ready.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 opdata1  input  32  dividend (rs value).
REQ-007 opdata2  input  32  divisor (rt value).
REQ-008 annul  input  1  cancel in-flight divide (exception/flush).
REQ-009 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 ready  output  1  result valid.
REQ-011 stall_req  output  1  pipeline stall request while divide is pending.

Function
REQ-012 The block SHALL be a radix-2 restoring divider with states IDLE, DIVZERO, ON, END and a 6-bit iteration counter.
REQ-013 IDLE: on an edge with start=1, annul=0, opdata2!=0 -> latch |opdata1|, |opdata2| (magnitude only when signed_div=1), both operand signs and signed_div, clear counter, go ON; with opdata2==0 -> go DIVZERO; otherwise stay IDLE.
REQ-014 Operand inputs SHALL be ignored after the start-sampling edge (E0) until the block returns to IDLE.
REQ-015 ON: each edge performs one shift/trial-subtract step on a 65-bit partial-remainder/quotient register and increments the counter; edges E1..E32 perform the 32 steps.
REQ-016 At E33 (ON, counter==32) the block SHALL register the final result, set ready=1, and go END.
REQ-017 Signed fix-up: quotient negated when signed_div=1 and operand signs differ; remainder negated when signed_div=1 and dividend negative; all arithmetic modulo 2^32.
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0x00000000 (no trap).
REQ-019 DIVZERO: at the next edge go END with result=64'h0 and ready=1 (ready high after E1).
REQ-020 END: hold result and ready=1 while start=1; on an edge with start=0 go IDLE, ready=0, result=64'h0.
REQ-021 stall_req SHALL be combinational: start & ~ready & ~annul.
REQ-022 annul=1 in DIVZERO or ON SHALL on that edge force IDLE, ready=0, result=64'h0; annul in IDLE blocks start; annul in END forces IDLE.
REQ-023 A start asserted in END SHALL NOT begin a new divide until the block has passed through IDLE (start must drop for at least one cycle).
REQ-024 Back-to-back divides SHALL each take full latency; no result forwarding between operations.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, counter 0, result 64'h0, ready 0, all latched operand/sign registers 0, taking priority over start and annul.
REQ-026 rst asserted mid-ON SHALL abandon the divide; no ready pulse follows.

Verification
REQ-027 DIVU 100/7: start=1, signed_div=0 -> ready rises after E33, result={32'd2, 32'd14}; stall_req high from E0 through cycle before ready.
REQ-028 DIV -7/2: opdata1=0xFFFFFFF9, opdata2=2 -> result={0xFFFFFFFF, 0xFFFFFFFD}; INT_MIN/-1 -> {0x00000000, 0x80000000}.
REQ-029 Divide by zero: opdata2=0 -> ready after E1, result=64'h0, start then dropped -> IDLE next edge.
REQ-030 annul at E10 during ON -> IDLE next edge, ready never asserts, stall_req low while annul=1; fresh start then completes normally in 33 edges.
REQ-031 rst at E20 during ON -> all outputs zero next cycle; opdata changes after E0 in a normal run do not alter result (0xFFFFFFFF/0x10 DIVU -> {0xF, 0x0FFFFFFF}).
REQ-032 start held in END for 5 cycles -> ready and result stable for all 5; start low one cycle -> IDLE, ready=0.

Source files
------------

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_if
//  Description : Execute-stage to divider handshake bundle (request, operands,
//                cancel, result and stall).
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stall_req
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stall_req
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : 32-bit radix-2 restoring divider (DIV/DIVU), 33-edge latency,
//                result {remainder, quotient} for the HI/LO pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [5:0] C_LAST_STEP = 6'd32;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_acc;      // {partial remainder[32:0], quotient[31:0]}
    logic [31:0] r_divisor;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_signed;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [33:0] w_trial;
    logic [64:0] w_acc_next;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    always_comb begin
        w_abs_a = (bus.signed_div && bus.opdata1[31]) ? (32'd0 - bus.opdata1) : bus.opdata1;
        w_abs_b = (bus.signed_div && bus.opdata2[31]) ? (32'd0 - bus.opdata2) : bus.opdata2;
    end

    // Trial subtract on the remainder shifted left by one; a borrow (bit 33)
    // means the divisor did not fit, so the shifted value is kept as-is.
    always_comb begin
        w_trial = r_acc[64:31] - {2'b00, r_divisor};
        if (w_trial[33]) begin
            w_acc_next = {r_acc[63:0], 1'b0};
        end else begin
            w_acc_next = {w_trial[32:0], r_acc[30:0], 1'b1};
        end
    end

    always_comb begin
        w_quo     = r_acc[31:0];
        w_rem     = r_acc[63:32];
        w_quo_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? (32'd0 - w_quo) : w_quo;
        w_rem_fix = (r_signed && r_sign_a) ? (32'd0 - w_rem) : w_rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_acc     <= 65'd0;
            r_divisor <= 32'd0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_signed  <= 1'b0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready  <= 1'b0;
                    r_result <= 64'd0;
                    if (bus.start && !bus.annul) begin
                        if (bus.opdata2 == 32'd0) begin
                            r_state <= S_DIVZERO;
                        end else begin
                            r_acc     <= {33'd0, w_abs_a};
                            r_divisor <= w_abs_b;
                            r_sign_a  <= bus.opdata1[31];
                            r_sign_b  <= bus.opdata2[31];
                            r_signed  <= bus.signed_div;
                            r_cnt     <= 6'd0;
                            r_state   <= S_ON;
                        end
                    end
                end

                S_DIVZERO: begin
                    r_result <= 64'd0;
                    if (bus.annul) begin
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_END;
                    end
                end

                S_ON: begin
                    if (bus.annul) begin
                        r_ready  <= 1'b0;
                        r_result <= 64'd0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == C_LAST_STEP) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end

                S_END: begin
                    // A held start must not re-trigger; only a visit to IDLE can.
                    if (bus.annul || !bus.start) begin
                        r_ready  <= 1'b0;
                        r_result <= 64'd0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_ready  <= 1'b0;
                    r_result <= 64'd0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result    = r_result;
    assign bus.ready     = r_ready;
    assign bus.stall_req = bus.start & ~r_ready & ~bus.annul;

endmodule
`default_nettype wire
